xor_crypt_stream: RTL and testbench
===================================

XOR_CRYPT_STREAM -- requirements
Module: xor_crypt_stream

Interface
REQ-001 SHALL have parameter LANES, default 8, giving the number of byte lanes per data word.
REQ-002 SHALL have parameter LEN_W, default 8, giving the width of the job length field.
REQ-003 SHALL have parameter PAD, 64 bits, default 64'hEE6B_0C4F_2474_0470, holding the keystream source pad.
REQ-004 SHALL have port clk, input, 1 bit: clock.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1 bit: job request, sampled in IDLE only.
REQ-007 SHALL have port key, input, 8*LANES bits: job key, latched on the accepted start.
REQ-008 SHALL have port len, input, LEN_W bits: number of words in the job, latched on the accepted start.
REQ-009 SHALL have port mode, input, 1 bit: 0 = ECB, 1 = CBC; latched on the accepted start.
REQ-010 SHALL have port dir, input, 1 bit: 0 = encrypt, 1 = decrypt; latched on the accepted start.
REQ-011 SHALL have port iv, input, 8*LANES bits: CBC initial chain value, latched on the accepted start.
REQ-012 SHALL have ports in_data (input, 8*LANES), in_valid (input, 1) and in_ready (output, 1): input word stream.
REQ-013 SHALL have ports out_data (output, 8*LANES), out_valid (output, 1) and out_ready (input, 1): output word stream.
REQ-014 SHALL have ports busy (output, 1; high in RUN) and done (output, 1; high in DONE).
REQ-015 SHALL have port ack, input, 1 bit: done acknowledge.

Function
REQ-016 SHALL compute, for each lane i with key byte k = key_q[8i+:8], idx = {k[3]^k[7], k[1]^k[5], (k[3]^k[7])|(k[2]^k[6])}.
REQ-017 SHALL use keystream byte ks[i] = PAD[idx +: 8], i.e. bit offset 0..7.
REQ-018 SHALL implement the FSM states IDLE, RUN and DONE; IDLE goes to RUN on start when len!=0, and to DONE on start when len==0.
REQ-019 SHALL go from RUN to DONE in the cycle after the output handshake of the len-th word.
REQ-020 SHALL go from DONE to IDLE on ack; start SHALL be ignored outside IDLE.
REQ-021 SHALL drive in_ready = (state==RUN) && (words accepted < len) && (!out_valid || out_ready).
REQ-022 SHALL, on an input handshake, register out_data = in_data ^ ks ^ chain and set out_valid on the next edge, giving a latency of one cycle.
REQ-023 SHALL use chain = 0 in ECB mode.
REQ-024 SHALL use chain = iv for the first word in CBC mode, then update it to out_data (encrypt) or to in_data (decrypt) after each accepted word.
REQ-025 SHALL hold out_data and out_valid stable while out_valid && !out_ready.
REQ-026 SHALL sustain one word per cycle when out_ready is held high.
REQ-027 SHALL count accepted words modulo 2^LEN_W with no wrap in use, since len bounds the count.
REQ-028 SHALL keep key, len, mode, dir and iv input changes during RUN from affecting the current job.

Reset
REQ-029 SHALL, on asynchronous reset (including mid-job), set the state to IDLE, clear the counters, chain, key_q and out_data, and drive out_valid, in_ready, busy and done to 0.
REQ-030 SHALL lose any in-flight word on reset; no output handshake SHALL occur in the first cycle after reset.

Configuration
REQ-031 SHALL compile the CBC datapath (chain register, iv and mode use) when macro XOR_CRYPT_CBC_EN is defined.
REQ-032 SHALL, without XOR_CRYPT_CBC_EN, ignore mode and iv, hold chain at 0 and run ECB only; ports SHALL remain present.

Structure
REQ-033 SHALL place the state encoding (IDLE, RUN, DONE), the default PAD constant and the keystream index function in shared package xor_crypt_pkg.
REQ-034 SHALL implement a per-lane keystream sub-module xor_ks_lane (key byte in, keystream byte out), instantiated LANES times.

Verification
REQ-035 SHALL cover: LANES=8, ECB, key=0, len=1, in=0 -> out=64'h7070_7070_7070_7070 one cycle after the handshake, then done.
REQ-036 SHALL cover: ECB, key bytes all 8'h08, in=0 -> every out byte 8'h23 (PAD[12:5]).
REQ-037 SHALL cover: CBC with key=0, iv=64'hFF..FF, len=2, encrypt of in 0,0 -> out 8F..8F then FF..FF; decrypting that output yields 0,0.
REQ-038 SHALL cover: len=4 with out_ready low for 3 cycles mid-stream -> out_data held, no word lost or duplicated, done after the 4th output.
REQ-039 SHALL cover: len=0 start -> DONE the next cycle with no out_valid; ack -> IDLE.
REQ-040 SHALL cover: reset asserted during RUN of a len=5 job -> all outputs 0 immediately; a new len=1 job afterwards completes correctly.

Source files
------------

// File: rtl/xor_crypt_pkg.sv
// xor_crypt_pkg: shared definitions for the XOR stream cipher block.
// Holds the job FSM encoding, the default keystream pad and the
// key-byte-to-pad-offset function used by every keystream lane.
package xor_crypt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } xc_state_t;

    localparam logic [63:0] XC_PAD_DEFAULT = 64'hEE6B_0C4F_2474_0470;

    // Bit offset (0..7) into the pad selected by one key byte.
    // Key bits 0 and 4 do not take part in the selection.
    function automatic logic [2:0] ks_idx(input logic [7:0] k);
        logic hi;
        hi     = k[3] ^ k[7];
        ks_idx = {hi, k[1] ^ k[5], hi | (k[2] ^ k[6])};
    endfunction

endpackage

// File: rtl/xor_ks_lane.sv
// xor_ks_lane: keystream byte for one lane, an 8-bit window of the pad
// whose offset is derived from that lane's key byte.
module xor_ks_lane
    import xor_crypt_pkg::*;
#(
    parameter logic [63:0] PAD = XC_PAD_DEFAULT
) (
    input  logic [7:0] key_byte_i,
    output logic [7:0] ks_byte_o
);

    logic [2:0] idx;
    logic       unused_key;

    // key bits 0 and 4 never reach the offset
    assign unused_key = key_byte_i[0] ^ key_byte_i[4];

    // select the pad window for this lane
    always_comb begin
        idx       = ks_idx(key_byte_i);
        ks_byte_o = PAD[{3'b000, idx} +: 8];
    end

endmodule

// File: rtl/xor_crypt_stream.sv
// xor_crypt_stream: byte-lane XOR stream cipher processing len-word jobs.
// out_data = in_data ^ keystream ^ chain, registered with one cycle latency.
// CBC chaining (mode/iv/dir) is compiled only when XOR_CRYPT_CBC_EN is defined;
// without it mode, dir and iv are ignored and every job runs as ECB.
//
// state | meaning
// IDLE  | waiting for start; job parameters latched when start is seen
// RUN   | streaming words; busy high
// DONE  | all len words handed off (or len was 0); done high until ack
module xor_crypt_stream
    import xor_crypt_pkg::*;
#(
    parameter int unsigned LANES = 8,
    parameter int unsigned LEN_W = 8,
    parameter logic [63:0] PAD   = XC_PAD_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [8*LANES-1:0] key,
    input  logic [LEN_W-1:0]   len,
    input  logic               mode,
    input  logic               dir,
    input  logic [8*LANES-1:0] iv,
    input  logic [8*LANES-1:0] in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [8*LANES-1:0] out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               done,
    input  logic               ack
);

    localparam int unsigned     W       = 8 * LANES;
    localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

    xc_state_t        state_q;
    logic [W-1:0]     key_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [W-1:0]     out_data_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             done_q;

    logic [W-1:0]     ks;
    logic [W-1:0]     chain;
    logic [W-1:0]     result;
    logic             in_hs;
    logic             out_hs;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        xor_ks_lane #(.PAD(PAD)) u_lane (
            .key_byte_i (key_q[8*i +: 8]),
            .ks_byte_o  (ks[8*i +: 8])
        );
    end

    // accept input only while words remain and the output slot is free or draining
    assign in_ready = (state_q == RUN) && (cnt_q < len_q) && (!out_valid_q || out_ready);
    assign in_hs    = in_ready && in_valid;
    assign out_hs   = out_valid_q && out_ready;
    assign result   = in_data ^ ks ^ chain;

`ifdef XOR_CRYPT_CBC_EN
    logic         mode_q;
    logic         dir_q;
    logic [W-1:0] chain_q;
    logic [W-1:0] chain_d;

    // chain seeds from iv at job start, then follows the ciphertext side of each word
    always_comb begin
        chain_d = chain_q;
        if (state_q == IDLE && start) begin
            chain_d = mode ? iv : '0;
        end else if (in_hs && mode_q) begin
            chain_d = dir_q ? in_data : result;
        end
    end

    // chain register and latched job mode/direction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_q <= '0;
            mode_q  <= 1'b0;
            dir_q   <= 1'b0;
        end else begin
            chain_q <= chain_d;
            if (state_q == IDLE && start) begin
                mode_q <= mode;
                dir_q  <= dir;
            end
        end
    end

    assign chain = chain_q;
`else
    logic unused_cbc;

    assign unused_cbc = mode ^ dir ^ (^iv);
    assign chain      = '0;
`endif

    // job FSM with the output word register and the accepted-word counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            key_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        key_q <= key;
                        len_q <= len;
                        cnt_q <= '0;
                        if (len != '0) begin
                            state_q <= RUN;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (in_hs) begin
                        out_data_q  <= result;
                        out_valid_q <= 1'b1;
                        cnt_q       <= cnt_q + CNT_ONE;
                    end else if (out_hs) begin
                        out_valid_q <= 1'b0;
                    end
                    // once every word is accepted, the next handoff is the last one
                    if (out_hs && (cnt_q == len_q)) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    if (ack) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_xor_crypt_stream.sv
// tb_xor_crypt_stream: randomized job bench for xor_crypt_stream with a
// word-level reference model (keystream from the pad, optional CBC chain).
// Expected CBC behaviour follows XOR_CRYPT_CBC_EN, as the design does.
module tb_xor_crypt_stream;

    localparam int          LANES   = 8;
    localparam int          LEN_W   = 8;
    localparam logic [63:0] PAD_REF = 64'hEE6B_0C4F_2474_0470;

`ifdef XOR_CRYPT_CBC_EN
    localparam bit CBC_EN = 1'b1;
`else
    localparam bit CBC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] key;
    logic [7:0]  len;
    logic        mode;
    logic        dir;
    logic [63:0] iv;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;
    logic        ack;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [63:0] job_in  [16];
    logic [63:0] job_exp [16];
    logic [63:0] job_out [16];

    xor_crypt_stream #(.LANES(LANES), .LEN_W(LEN_W), .PAD(PAD_REF)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .key       (key),
        .len       (len),
        .mode      (mode),
        .dir       (dir),
        .iv        (iv),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .ack       (ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        vec_cnt++;
        if (obs !== req) begin
            err_cnt++;
            $display("FAIL %s: got %h, want %h", tag, obs, req);
        end
    endtask

    // keystream word: each lane picks an 8-bit slice of the pad at an offset from its key byte
    function automatic logic [63:0] model_ks(input logic [63:0] k);
        logic [63:0] r;
        logic [63:0] shifted;
        logic [7:0]  kb;
        int          b2, b1, b0, off;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            kb      = k[8*i +: 8];
            b2      = kb[3] ^ kb[7];
            b1      = kb[1] ^ kb[5];
            b0      = b2 | (kb[2] ^ kb[6]);
            off     = b2 * 4 + b1 * 2 + b0;
            shifted = PAD_REF >> off;
            r[8*i +: 8] = shifted[7:0];
        end
        return r;
    endfunction

    // runs one job from IDLE; sm: 0 = always ready, 1 = random, 2 = 3-cycle stall mid-stream
    task automatic run_job(input logic [63:0] k, input int n, input bit m, input bit d,
                           input logic [63:0] v, input int sm);
        logic [63:0] ks_w, ch;
        int sent, rcv, cyc;
        bit cbc;
        ks_w = model_ks(k);
        cbc  = CBC_EN && m;
        ch   = cbc ? v : 64'h0;
        for (int j = 0; j < n; j++) begin
            job_exp[j] = job_in[j] ^ ks_w ^ ch;
            if (cbc) ch = d ? job_in[j] : job_exp[j];
        end

        key = k; len = 8'(n); mode = m; dir = d; iv = v; start = 1'b1;
        out_ready = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        key   = {$urandom, $urandom};
        len   = 8'($urandom);
        mode  = 1'($urandom);
        dir   = 1'($urandom);
        iv    = {$urandom, $urandom};

        if (n == 0) begin
            chk("len0_done", done, 1);
            chk("len0_busy", busy, 0);
            chk("len0_out_valid", out_valid, 0);
        end else begin
            chk("run_busy", busy, 1);
            sent = 0; rcv = 0; cyc = 0;
            while (rcv < n && cyc < 300) begin
                chk("out_valid", out_valid, (sent > rcv));
                if (out_valid) chk("out_data", out_data, job_exp[rcv]);
                case (sm)
                    1:       out_ready = ($urandom_range(0, 2) != 0);
                    2:       out_ready = !(cyc >= 2 && cyc < 5);
                    default: out_ready = 1'b1;
                endcase
                in_valid = (sent < n) && ((sm != 1) || ($urandom_range(0, 3) != 0));
                in_data  = in_valid ? job_in[sent] : {$urandom, $urandom};
                #1;
                chk("in_ready", in_ready, (sent < n) && (!(sent > rcv) || out_ready));
                if (out_valid && out_ready) begin
                    job_out[rcv] = out_data;
                    rcv++;
                end
                if (in_valid && in_ready) sent++;
                @(negedge clk);
                cyc++;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            chk("words_out", rcv, n);
            if (sm == 0) chk("throughput_cycles", cyc, n + 1);
            chk("end_done", done, 1);
            chk("end_busy", busy, 0);
            chk("end_out_valid", out_valid, 0);
        end
    endtask

    // in DONE: a start must be ignored, then ack returns to IDLE
    task automatic close_job();
        start = 1'b1; len = 8'd3; ack = 1'b0;
        @(negedge clk);
        chk("start_ignored_done", done, 1);
        chk("start_ignored_busy", busy, 0);
        start = 1'b0; ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("ack_done", done, 0);
        chk("ack_busy", busy, 0);
    endtask

    initial begin
        logic [63:0] e0, e1;
        reset = 1'b1; start = 1'b0; key = '0; len = '0; mode = 1'b0; dir = 1'b0;
        iv = '0; in_data = '0; in_valid = 1'b0; out_ready = 1'b1; ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        reset = 1'b0;
        @(negedge clk);

        // key 0, single zero word
        job_in[0] = 64'h0;
        run_job(64'h0, 1, 1'b0, 1'b0, 64'h0, 0);
        chk("key0_word", job_out[0], 64'h7070_7070_7070_7070);
        close_job();

        // key bytes 0x08 select pad offset 5
        job_in[0] = 64'h0;
        run_job({8{8'h08}}, 1, 1'b0, 1'b0, 64'h0, 0);
        chk("key08_word", job_out[0], 64'h2323_2323_2323_2323);
        close_job();

        // CBC encrypt then decrypt round trip
        e0 = CBC_EN ? 64'h8F8F_8F8F_8F8F_8F8F : 64'h7070_7070_7070_7070;
        e1 = CBC_EN ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h7070_7070_7070_7070;
        job_in[0] = 64'h0; job_in[1] = 64'h0;
        run_job(64'h0, 2, 1'b1, 1'b0, {64{1'b1}}, 0);
        chk("cbc_enc_w0", job_out[0], e0);
        chk("cbc_enc_w1", job_out[1], e1);
        close_job();
        job_in[0] = job_out[0]; job_in[1] = job_out[1];
        run_job(64'h0, 2, 1'b1, 1'b1, {64{1'b1}}, 0);
        chk("cbc_dec_w0", job_out[0], 64'h0);
        chk("cbc_dec_w1", job_out[1], 64'h0);
        close_job();

        // len 4 with a three-cycle output stall
        for (int j = 0; j < 4; j++) job_in[j] = {$urandom, $urandom};
        run_job({$urandom, $urandom}, 4, 1'b0, 1'b0, 64'h0, 2);
        close_job();

        // empty job
        run_job({$urandom, $urandom}, 0, 1'b0, 1'b0, 64'h0, 0);
        close_job();

        // reset in the middle of a len 5 job
        key = {$urandom, $urandom}; len = 8'd5; mode = 1'b0; dir = 1'b0; start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = {$urandom, $urandom};
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_out_data", out_data, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("postrst_out_valid", out_valid, 0);
        in_valid = 1'b0;
        job_in[0] = {$urandom, $urandom};
        run_job({$urandom, $urandom}, 1, 1'b0, 1'b0, 64'h0, 0);
        close_job();

        // randomized jobs
        for (int r = 0; r < 14; r++) begin
            int n;
            n = $urandom_range(1, 12);
            for (int j = 0; j < n; j++) job_in[j] = {$urandom, $urandom};
            run_job({$urandom, $urandom}, n, 1'($urandom), 1'($urandom),
                    {$urandom, $urandom}, (r % 3 == 0) ? 0 : 1);
            close_job();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
